morse_text_scroller: RTL and testbench

- Downstream stage of the Morse capture/decode path. Consumes each completed decoded word and appends its characters, followed by one blank separator, to a character FIFO.
- Drains the FIFO at a fixed rate into a MAX_CHARS-wide display window, so the decoded text scrolls right-to-left across the seven-segment character decoders.
- Lets text longer than the display be read.

---
 rtl/morse_text_scroller.sv | 159 +++++++++++++++
 tb/tb_morse_text_scroller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/morse_text_scroller.sv
// morse_text_scroller: appends each completed decoded word (plus one blank separator) to a
// character FIFO and drains that FIFO at a fixed rate into a scrolling display window.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   ce           clock enable; all state frozen while low
//   clear        synchronous clear (qualified by ce), highest priority
//   word_in      decoded word, slot 0 (LSBs) = most recent char, unused slots 0
//   word_ended   level, high while the word is complete (rising edge starts an append)
//   error        decoder error flag; a word started with error=1 is rejected
//   disp         display window, slot 0 = rightmost digit
//   fifo_count   characters waiting in the FIFO
//   busy         append FSM not idle
//   overflow     sticky, a character was dropped on a full FIFO
//   word_dropped one-cycle pulse, a word was rejected
module morse_text_scroller #(
  parameter int unsigned CHAR_W     = 5,
  parameter int unsigned MAX_CHARS  = 8,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned SCROLL_DIV = 12500000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ce,
  input  logic                        clear,
  input  logic [CHAR_W*MAX_CHARS-1:0] word_in,
  input  logic                        word_ended,
  input  logic                        error,
  output logic [CHAR_W*MAX_CHARS-1:0] disp,
  output logic [$clog2(DEPTH):0]      fifo_count,
  output logic                        busy,
  output logic                        overflow,
  output logic                        word_dropped
);

  localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH) + 1;
  localparam int unsigned DivW  = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int unsigned IdxW  = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
  localparam int unsigned LenW  = $clog2(MAX_CHARS + 1);
  localparam int unsigned WordW = CHAR_W * MAX_CHARS;

  typedef enum logic [1:0] {StIdle, StLoad, StPush, StSep} state_e;

  state_e            state;
  logic              we_prev;
  logic [WordW-1:0]  word_q;
  logic [IdxW-1:0]   idx_q;
  logic [CHAR_W-1:0] mem [DEPTH];
  logic [PtrW-1:0]   wr_ptr, rd_ptr;
  logic [CntW-1:0]   count_q;
  logic [DivW-1:0]   div_q;
  logic [WordW-1:0]  disp_q;
  logic              overflow_q;
  logic              dropped_q;

  logic [CHAR_W-1:0] slots [MAX_CHARS];
  logic [LenW-1:0]   len;
  logic              start, wrap, pop, push, full, do_push;
  logic [CHAR_W-1:0] push_data;

  always_comb begin
    for (int i = 0; i < MAX_CHARS; i++) slots[i] = word_q[i*CHAR_W +: CHAR_W];
  end

  // Length runs to the highest nonzero slot so interior blanks survive.
  always_comb begin
    len = '0;
    for (int i = 0; i < MAX_CHARS; i++) begin
      if (slots[i] != '0) len = LenW'(i + 1);
    end
  end

  assign start     = word_ended && !we_prev;
  assign wrap      = (div_q == DivW'(SCROLL_DIV - 1));
  assign pop       = wrap && (count_q != '0);
  assign push      = (state == StPush) || (state == StSep);
  assign push_data = (state == StSep) ? '0 : slots[idx_q];
  assign full      = (count_q == CntW'(DEPTH));
  // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
  assign do_push   = push && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      we_prev    <= 1'b0;
      word_q     <= '0;
      idx_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      div_q      <= '0;
      disp_q     <= '0;
      overflow_q <= 1'b0;
      dropped_q  <= 1'b0;
    end else if (ce) begin
      we_prev <= word_ended;
      if (clear) begin
        state      <= StIdle;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count_q    <= '0;
        div_q      <= '0;
        disp_q     <= '0;
        overflow_q <= 1'b0;
        dropped_q  <= 1'b0;
      end else begin
        dropped_q <= start && (error || (state != StIdle));
        div_q     <= wrap ? '0 : div_q + 1'b1;
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
          disp_q <= {disp_q[WordW-CHAR_W-1:0], mem[rd_ptr]};
        end
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (push && !do_push) overflow_q <= 1'b1;
        case ({do_push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
        case (state)
          StIdle: begin
            if (start && !error) begin
              word_q <= word_in;
              state  <= StLoad;
            end
          end
          StLoad: begin
            if (len == '0) begin
              state <= StIdle;
            end else begin
              idx_q <= IdxW'(len - LenW'(1));
              state <= StPush;
            end
          end
          StPush: begin
            if (idx_q == '0) state <= StSep;
            else idx_q <= idx_q - 1'b1;
          end
          StSep:   state <= StIdle;
          default: state <= StIdle;
        endcase
      end
    end
  end

  // Storage only; occupancy is tracked by the pointers and count above.
  always_ff @(posedge clk) begin
    if (ce && !clear && do_push) mem[wr_ptr] <= push_data;
  end

  assign disp         = disp_q;
  assign fifo_count   = count_q;
  assign busy         = (state != StIdle);
  assign overflow     = overflow_q;
  assign word_dropped = dropped_q;

endmodule

// File: tb/tb_morse_text_scroller.sv
// Directed bench for morse_text_scroller. Instance A (DEPTH=32, SCROLL_DIV=4) covers append
// timing, scrolling, rejected words, ce freeze, empty words and async reset. Instance B
// (DEPTH=8, SCROLL_DIV=64) covers overflow, retained order and clear.
module tb_morse_text_scroller;

  localparam int unsigned CW = 5;
  localparam int unsigned MC = 8;

  logic clk, rst_n, ce;
  logic clear_a, we_a, err_a, clear_b, we_b, err_b;
  logic [CW*MC-1:0] win_a, win_b, disp_a, disp_b;
  logic [5:0] cnt_a;
  logic [3:0] cnt_b;
  logic busy_a, ovf_a, drop_a, busy_b, ovf_b, drop_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [CW*MC-1:0] bw [3];

  morse_text_scroller #(.CHAR_W(CW), .MAX_CHARS(MC), .DEPTH(32), .SCROLL_DIV(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .ce(ce), .clear(clear_a), .word_in(win_a),
    .word_ended(we_a), .error(err_a), .disp(disp_a), .fifo_count(cnt_a),
    .busy(busy_a), .overflow(ovf_a), .word_dropped(drop_a)
  );

  morse_text_scroller #(.CHAR_W(CW), .MAX_CHARS(MC), .DEPTH(8), .SCROLL_DIV(64)) dut_b (
    .clk(clk), .rst_n(rst_n), .ce(ce), .clear(clear_b), .word_in(win_b),
    .word_ended(we_b), .error(err_b), .disp(disp_b), .fifo_count(cnt_b),
    .busy(busy_b), .overflow(ovf_b), .word_dropped(drop_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (ce) cyc++;
  endtask

  task automatic wait_idle_b();
    int n = 0;
    while (busy_b && n < 40) begin
      tick();
      n++;
    end
    chk("b_idle_timeout", 64'(busy_b), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b1;
    clear_a = 1'b0; we_a = 1'b0; err_a = 1'b0; win_a = '0;
    clear_b = 1'b0; we_b = 1'b0; err_b = 1'b0; win_b = '0;
    bw[0] = {5'd0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
    bw[1] = {5'd0, 5'd0, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16};
    bw[2] = {5'd0, 5'd0, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26};
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_disp", 64'(disp_a), 64'd0);
    chk("rst_count", 64'(cnt_a), 64'd0);
    chk("rst_flags", {61'd0, busy_a, ovf_a, drop_a}, 64'd0);

    // First word: slots {2:1, 1:2, 0:3}; edge sampled at E6, pushes at E8..E11.
    repeat (5) tick();
    win_a = {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd2, 5'd3};
    we_a = 1'b1;
    tick(); chk("w1_load_busy", 64'(busy_a), 64'd1);
    tick(); chk("w1_no_push_yet", 64'(cnt_a), 64'd0);
    tick(); chk("w1_first_push", 64'(cnt_a), 64'd1);
    tick(); tick();
    tick(); chk("w1_peak", 64'(cnt_a), 64'd4);
    chk("w1_busy_fall", 64'(busy_a), 64'd0);
    tick(); chk("w1_pop1_count", 64'(cnt_a), 64'd3);
    chk("w1_pop1_disp", 64'(disp_a), 64'd1);
    repeat (12) tick();
    chk("w1_disp", 64'(disp_a), 64'({5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0}));
    chk("w1_drained", 64'(cnt_a), 64'd0);

    // Rising edge with error: rejected.
    we_a = 1'b0; tick();
    err_a = 1'b1; we_a = 1'b1;
    tick(); chk("err_drop", 64'(drop_a), 64'd1);
    chk("err_busy", 64'(busy_a), 64'd0);
    err_a = 1'b0; we_a = 1'b0;
    tick(); chk("err_drop_pulse", 64'(drop_a), 64'd0);
    chk("err_count", 64'(cnt_a), 64'd0);

    // Second rising edge during PUSH: only the first word goes in.
    win_a = {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd6, 5'd7};
    we_a = 1'b1; tick();
    we_a = 1'b0; tick();
    win_a = {8{5'd31}}; we_a = 1'b1;
    tick(); chk("busy_drop", 64'(drop_a), 64'd1);
    chk("busy_drop_cnt", 64'(cnt_a), 64'd1);
    tick(); chk("busy_drop_pulse", 64'(drop_a), 64'd0);
    tick(); chk("w2_push_pop", 64'(cnt_a), 64'd2);
    chk("w2_idle", 64'(busy_a), 64'd0);
    we_a = 1'b0; win_a = '0;
    repeat (8) tick();
    chk("w2_drained", 64'(cnt_a), 64'd0);
    chk("w2_disp", 64'(disp_a), 64'({5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd6, 5'd7, 5'd0}));

    // ce freeze mid-word, right before a scroll wrap.
    win_a = {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd9};
    we_a = 1'b1;
    tick(); tick(); tick();
    ce = 1'b0;
    repeat (10) tick();
    chk("ce_cnt", 64'(cnt_a), 64'd1);
    chk("ce_busy", 64'(busy_a), 64'd1);
    chk("ce_disp", 64'(disp_a), 64'({5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd6, 5'd7, 5'd0}));
    ce = 1'b1;
    tick(); chk("ce_resume_cnt", 64'(cnt_a), 64'd1);
    chk("ce_resume_busy", 64'(busy_a), 64'd0);
    chk("ce_resume_disp", 64'(disp_a), 64'({5'd1, 5'd2, 5'd3, 5'd0, 5'd6, 5'd7, 5'd0, 5'd9}));

    // All-zero word: LOAD then IDLE with nothing pushed.
    we_a = 1'b0; tick();
    win_a = '0; we_a = 1'b1;
    tick(); chk("zero_load", 64'(busy_a), 64'd1);
    tick(); chk("zero_idle", 64'(busy_a), 64'd0);
    chk("zero_nodrop", 64'(drop_a), 64'd0);
    chk("zero_cnt", 64'(cnt_a), 64'd1);

    // Async reset mid-PUSH.
    we_a = 1'b0; tick();
    win_a = {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd1, 5'd1}; we_a = 1'b1;
    tick(); tick(); tick();
    chk("pre_rst_cnt", 64'(cnt_a), 64'd1);
    chk("pre_rst_busy", 64'(busy_a), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_disp", 64'(disp_a), 64'd0);
    chk("arst_cnt", 64'(cnt_a), 64'd0);
    chk("arst_flags", {61'd0, busy_a, ovf_a, drop_a}, 64'd0);

    // Instance B: overflow with three 6-char words into DEPTH=8.
    we_a = 1'b0; win_a = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;
    for (int w = 0; w < 3; w++) begin
      win_b = bw[w]; we_b = 1'b1;
      tick();
      we_b = 1'b0;
      wait_idle_b();
    end
    chk("ovf_cnt", 64'(cnt_b), 64'd8);
    chk("ovf_flag", 64'(ovf_b), 64'd1);
    while (cyc < 511) tick();
    chk("b_cnt_511", 64'(cnt_b), 64'd1);
    tick();
    chk("b_cnt_512", 64'(cnt_b), 64'd0);
    chk("b_order", 64'(disp_b), 64'({5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd0, 5'd11}));
    chk("b_ovf_sticky", 64'(ovf_b), 64'd1);

    // Clear mid-stream.
    win_b = {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd2, 5'd3}; we_b = 1'b1;
    tick();
    we_b = 1'b0;
    wait_idle_b();
    chk("b_pre_clear", 64'(cnt_b), 64'd3);
    clear_b = 1'b1;
    tick();
    clear_b = 1'b0;
    chk("clr_disp", 64'(disp_b), 64'd0);
    chk("clr_cnt", 64'(cnt_b), 64'd0);
    chk("clr_ovf", 64'(ovf_b), 64'd0);
    chk("clr_busy", 64'(busy_b), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
